player_executor: RTL and testbench

//  Far end of the 16-bit player instruction bus driven by the game state machine.

---
 rtl/player_executor.sv | 158 +++++++++++++++
 tb/tb_player_executor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/player_executor.sv
// Player executor: decodes 16-bit player instructions and updates position, HP and life state.
// Non-MOV ops fire on a word change; MOV repeats every MOVE_DIV cycles while held in ACTIVE.
module player_executor #(
  parameter logic [9:0] X_MIN    = 10'd8,
  parameter logic [9:0] X_MAX    = 10'd200,
  parameter logic [9:0] Y_MIN    = 10'd8,
  parameter logic [9:0] Y_MAX    = 10'd120,
  parameter logic [9:0] X_START  = 10'd104,
  parameter logic [9:0] Y_START  = 10'd64,
  parameter logic [9:0] STEP     = 10'd2,
  parameter int         MOVE_DIV = 16,
  parameter logic [7:0] MAX_HP   = 8'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  output logic [9:0]  player_x,
  output logic [9:0]  player_y,
  output logic [7:0]  player_hp,
  output logic        is_death,
  output logic        is_move,
  output logic [1:0]  phase
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);

  localparam logic [3:0] OP_HPY = 4'd1;
  localparam logic [3:0] OP_DPY = 4'd2;
  localparam logic [3:0] OP_IDG = 4'd3;
  localparam logic [3:0] OP_SDG = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHP = 4'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [7:0]       hp_q, hp_d;
  logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
  logic [15:0]      prev_instr_q;
  logic             is_move_q, is_move_d;

  logic [3:0]  opcode_s;
  logic [3:0]  dir_s;
  logic [7:0]  imm_s;
  logic        is_new_s;
  logic        hp_op_s;
  logic [9:0]  nx_s, ny_s;
  logic [10:0] x_sum_s, y_sum_s;
  logic [8:0]  hp_sum_s;
  logic [7:0]  hpy_val_s, dpy_val_s, shp_val_s;

  assign opcode_s = instr[15:12];
  assign dir_s    = instr[11:8];
  assign imm_s    = instr[7:0];
  assign is_new_s = (instr != prev_instr_q);
  assign hp_op_s  = (opcode_s == OP_HPY) || (opcode_s == OP_DPY) || (opcode_s == OP_SHP);

  // Candidate position for one step in the requested direction, clamped at the box walls
  always_comb begin
    nx_s    = x_q;
    ny_s    = y_q;
    x_sum_s = {1'b0, x_q} + {1'b0, STEP};
    y_sum_s = {1'b0, y_q} + {1'b0, STEP};
    case (dir_s)
      4'd0: ny_s = (y_q < (Y_MIN + STEP)) ? Y_MIN : (y_q - STEP);
      4'd1: nx_s = (x_sum_s > {1'b0, X_MAX}) ? X_MAX : x_sum_s[9:0];
      4'd2: ny_s = (y_sum_s > {1'b0, Y_MAX}) ? Y_MAX : y_sum_s[9:0];
      4'd3: nx_s = (x_q < (X_MIN + STEP)) ? X_MIN : (x_q - STEP);
      default: begin
        nx_s = x_q;
        ny_s = y_q;
      end
    endcase
  end

  // Candidate HP results for heal, damage and set
  always_comb begin
    hp_sum_s  = {1'b0, hp_q} + {1'b0, imm_s};
    hpy_val_s = (hp_sum_s > {1'b0, MAX_HP}) ? MAX_HP : hp_sum_s[7:0];
    dpy_val_s = (imm_s >= hp_q) ? 8'd0 : (hp_q - imm_s);
    shp_val_s = (imm_s > MAX_HP) ? MAX_HP : imm_s;
  end

  // Next-state: opcode execution, move rate limiting and life-state transitions
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    hp_d       = hp_q;
    move_cnt_d = '0;
    is_move_d  = 1'b0;

    if (is_new_s && (opcode_s == OP_IDG)) begin
      x_d     = X_START;
      y_d     = Y_START;
      hp_d    = MAX_HP;
      state_d = ACTIVE;
    end else if (state_q == DEAD) begin
      state_d = DEAD;
    end else if (is_new_s && hp_op_s) begin
      case (opcode_s)
        OP_HPY:  hp_d = hpy_val_s;
        OP_DPY:  hp_d = dpy_val_s;
        OP_SHP:  hp_d = shp_val_s;
        default: hp_d = hp_q;
      endcase
      state_d = (hp_d == 8'd0) ? DEAD : state_q;
    end else if (is_new_s && (opcode_s == OP_SDG)) begin
      state_d = IDLE;
    end else if ((state_q == ACTIVE) && (opcode_s == OP_MOV)) begin
      move_cnt_d = (move_cnt_q == CNT_LAST) ? '0 : (move_cnt_q + 1'b1);
      if (move_cnt_q == '0) begin
        x_d       = nx_s;
        y_d       = ny_s;
        is_move_d = (nx_s != x_q) || (ny_s != y_q);
      end else begin
        is_move_d = 1'b0;
      end
    end else begin
      move_cnt_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= X_START;
      y_q          <= Y_START;
      hp_q         <= MAX_HP;
      move_cnt_q   <= '0;
      prev_instr_q <= 16'h0000;
      is_move_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hp_q         <= hp_d;
      move_cnt_q   <= move_cnt_d;
      prev_instr_q <= instr;
      is_move_q    <= is_move_d;
    end
  end

  assign player_x  = x_q;
  assign player_y  = y_q;
  assign player_hp = hp_q;
  assign is_death  = (state_q == DEAD);
  assign is_move   = is_move_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_player_executor.sv
// Scoreboard bench for player_executor: each driven cycle queues its hand-computed expected
// outputs; an independent monitor pops one entry per clock and compares.
module tb_player_executor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic [9:0]  player_x, player_y;
  logic [7:0]  player_hp;
  logic        is_death, is_move;
  logic [1:0]  phase;

  typedef struct {
    int         id;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] hp;
    logic [1:0] ph;
    logic       mv;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  player_executor dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .player_x (player_x),
    .player_y (player_y),
    .player_hp(player_hp),
    .is_death (is_death),
    .is_move  (is_move),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [15:0] w, input logic [9:0] ex,
                      input logic [9:0] ey, input logic [7:0] ehp, input logic [1:0] eph,
                      input logic emv);
    exp_t e;
    @(negedge clk);
    rst   = r;
    instr = w;
    e.id = n_step; e.x = ex; e.y = ey; e.hp = ehp; e.ph = eph; e.mv = emv;
    sb_q.push_back(e);
    n_step++;
  endtask

  // Monitor: outputs are valid every cycle, one queued expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (player_x !== e.x || player_y !== e.y || player_hp !== e.hp || phase !== e.ph ||
            is_move !== e.mv || is_death !== (e.ph == 2'd2)) begin
          n_fail++;
          $display("FAIL chk%0d: got x=%0d y=%0d hp=%0d ph=%0d mv=%0d death=%0d, want x=%0d y=%0d hp=%0d ph=%0d mv=%0d death=%0d",
                   e.id, player_x, player_y, player_hp, phase, is_move, is_death,
                   e.x, e.y, e.hp, e.ph, e.mv, (e.ph == 2'd2));
        end
      end
    end
  end

  initial begin
    logic [9:0] ex;
    // reset and idle
    step(1'b1, 16'h0000, 10'd104, 10'd64, 8'd100, 2'd0, 1'b0);
    step(1'b1, 16'h0000, 10'd104, 10'd64, 8'd100, 2'd0, 1'b0);
    step(1'b0, 16'h0000, 10'd104, 10'd64, 8'd100, 2'd0, 1'b0);
    // HP ops in IDLE, edge detect, heal saturation
    step(1'b0, 16'h2028, 10'd104, 10'd64, 8'd60,  2'd0, 1'b0);
    step(1'b0, 16'h0000, 10'd104, 10'd64, 8'd60,  2'd0, 1'b0);
    step(1'b0, 16'h2028, 10'd104, 10'd64, 8'd20,  2'd0, 1'b0);
    step(1'b0, 16'h2028, 10'd104, 10'd64, 8'd20,  2'd0, 1'b0);
    step(1'b0, 16'h1064, 10'd104, 10'd64, 8'd100, 2'd0, 1'b0);
    step(1'b0, 16'h2028, 10'd104, 10'd64, 8'd60,  2'd0, 1'b0);
    // MOV ignored in IDLE, then IDG
    step(1'b0, 16'h5100, 10'd104, 10'd64, 8'd60,  2'd0, 1'b0);
    step(1'b0, 16'h3000, 10'd104, 10'd64, 8'd100, 2'd1, 1'b0);
    // MOV RIGHT held 33 cycles: moves at cycles 0, 16, 32
    for (int i = 0; i < 33; i++) begin
      ex = 10'd104 + 10'd2 * 10'(i / 16 + 1);
      step(1'b0, 16'h5100, ex, 10'd64, 8'd100, 2'd1, (i % 16) == 0);
    end
    // walk to the right wall with fresh MOV words
    for (int k = 0; k < 45; k++) begin
      ex = 10'd110 + 10'd2 * 10'(k);
      step(1'b0, 16'h0000, ex, 10'd64, 8'd100, 2'd1, 1'b0);
      step(1'b0, 16'h5100, ex + 10'd2, 10'd64, 8'd100, 2'd1, 1'b1);
    end
    step(1'b0, 16'h0000, 10'd200, 10'd64, 8'd100, 2'd1, 1'b0);
    step(1'b0, 16'h5100, 10'd200, 10'd64, 8'd100, 2'd1, 1'b0);
    // other directions, invalid direction, direction change keeps counter
    step(1'b0, 16'h0000, 10'd200, 10'd64, 8'd100, 2'd1, 1'b0);
    step(1'b0, 16'h5300, 10'd198, 10'd64, 8'd100, 2'd1, 1'b1);
    step(1'b0, 16'h0000, 10'd198, 10'd64, 8'd100, 2'd1, 1'b0);
    step(1'b0, 16'h5000, 10'd198, 10'd62, 8'd100, 2'd1, 1'b1);
    step(1'b0, 16'h0000, 10'd198, 10'd62, 8'd100, 2'd1, 1'b0);
    step(1'b0, 16'h5200, 10'd198, 10'd64, 8'd100, 2'd1, 1'b1);
    step(1'b0, 16'h0000, 10'd198, 10'd64, 8'd100, 2'd1, 1'b0);
    step(1'b0, 16'h5700, 10'd198, 10'd64, 8'd100, 2'd1, 1'b0);
    step(1'b0, 16'h5300, 10'd198, 10'd64, 8'd100, 2'd1, 1'b0);
    // SDG holds position, MOV ignored in IDLE, IDG respawns
    step(1'b0, 16'h4000, 10'd198, 10'd64, 8'd100, 2'd0, 1'b0);
    step(1'b0, 16'h5000, 10'd198, 10'd64, 8'd100, 2'd0, 1'b0);
    step(1'b0, 16'h3000, 10'd104, 10'd64, 8'd100, 2'd1, 1'b0);
    // SHP with saturation, then death and DEAD lockout
    step(1'b0, 16'h5100, 10'd106, 10'd64, 8'd100, 2'd1, 1'b1);
    step(1'b0, 16'h6014, 10'd106, 10'd64, 8'd20,  2'd1, 1'b0);
    step(1'b0, 16'h60FF, 10'd106, 10'd64, 8'd100, 2'd1, 1'b0);
    step(1'b0, 16'h6014, 10'd106, 10'd64, 8'd20,  2'd1, 1'b0);
    step(1'b0, 16'h2032, 10'd106, 10'd64, 8'd0,   2'd2, 1'b0);
    step(1'b0, 16'h5000, 10'd106, 10'd64, 8'd0,   2'd2, 1'b0);
    step(1'b0, 16'h1010, 10'd106, 10'd64, 8'd0,   2'd2, 1'b0);
    step(1'b0, 16'h3000, 10'd104, 10'd64, 8'd100, 2'd1, 1'b0);
    // reset during held MOV UP
    step(1'b0, 16'h5000, 10'd104, 10'd62, 8'd100, 2'd1, 1'b1);
    step(1'b0, 16'h5000, 10'd104, 10'd62, 8'd100, 2'd1, 1'b0);
    step(1'b1, 16'h5000, 10'd104, 10'd64, 8'd100, 2'd0, 1'b0);
    step(1'b1, 16'h5000, 10'd104, 10'd64, 8'd100, 2'd0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 16'h5000, 10'd104, 10'd64, 8'd100, 2'd0, 1'b0);
    end
    step(1'b0, 16'h3000, 10'd104, 10'd64, 8'd100, 2'd1, 1'b0);
    step(1'b0, 16'h5000, 10'd104, 10'd62, 8'd100, 2'd1, 1'b1);
    // a non-zero word held through reset executes once after release
    step(1'b1, 16'h2028, 10'd104, 10'd64, 8'd100, 2'd0, 1'b0);
    step(1'b0, 16'h2028, 10'd104, 10'd64, 8'd60,  2'd0, 1'b0);
    step(1'b0, 16'h2028, 10'd104, 10'd64, 8'd60,  2'd0, 1'b0);

    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
